// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter that shares one combinational ALU between two requesters.
//   A request is accepted in IDLE with a valid/ready handshake. The operands are
//   driven to the ALU for one EXEC cycle, and a one-cycle response pulse is raised in DONE.
//
// Parameters
//   W    operand/result width
//   OPW  opcode width (0=NOP,1=ADD,2=SUB,3=AND,4=OR,5=XOR,6=NOR)
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   reqN_valid/op/a/b            requester N operation
//   reqN_ready                   requester N accepted this cycle (combinational)
//   alu_a, alu_b, alu_op         ALU drive, zero/NOP outside EXEC
//   alu_out                      ALU result (combinational)
//   rsp0_valid, rsp1_valid       one-cycle response pulse per requester
//   rsp_data                     registered result, held between responses
//   rsp_zero, rsp_ovf            result flags, present only with ALU_ARB_FLAGS_EN
//
// Optional feature macro: ALU_ARB_FLAGS_EN
//
// state | meaning
// IDLE  | arbitrate, accept one request
// EXEC  | drive ALU from latched operands, capture result
// DONE  | pulse response for the served requester, rotate priority
module alu_arbiter #(
  parameter int W   = 32,
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_out,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
`ifdef ALU_ARB_FLAGS_EN
  output logic           rsp_zero,
  output logic           rsp_ovf,
`endif
  output logic [W-1:0]   rsp_data
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state_q, state_d;
  logic           prio_q;     // 0: req0 wins a tie, 1: req1 wins a tie
  logic           id_q;
  logic [OPW-1:0] op_q;
  logic [W-1:0]   a_q, b_q, result_q;
  logic           grant_vld, grant_id, accept;

  // A tie goes to the priority pointer. Otherwise the single valid requester wins.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? prio_q : req1_valid;
  end

  assign accept = (state_q == IDLE) && grant_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept && !grant_id;
    req1_ready = accept &&  grant_id;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = '0;
    if (state_q == EXEC) begin
      alu_a  = a_q;
      alu_b  = b_q;
      alu_op = op_q;
    end
    rsp0_valid = (state_q == DONE) && !id_q;
    rsp1_valid = (state_q == DONE) &&  id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        id_q <= grant_id;
        op_q <= grant_id ? req1_op : req0_op;
        a_q  <= grant_id ? req1_a  : req0_a;
        b_q  <= grant_id ? req1_b  : req0_b;
      end
      if (state_q == EXEC) result_q <= alu_out;
      if (state_q == DONE) prio_q   <= ~id_q;
    end
  end

  assign rsp_data = result_q;

`ifdef ALU_ARB_FLAGS_EN
  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(2);

  logic ovf_d;

  always_comb begin
    ovf_d = 1'b0;
    if (op_q == OP_ADD)
      ovf_d = (a_q[W-1] == b_q[W-1]) && (alu_out[W-1] != a_q[W-1]);
    else if (op_q == OP_SUB)
      ovf_d = (a_q[W-1] != b_q[W-1]) && (alu_out[W-1] != a_q[W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_zero <= (alu_out == '0);
      rsp_ovf  <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_data;
  logic        rsp0_valid, rsp1_valid;
`ifdef ALU_ARB_FLAGS_EN
  logic        rsp_zero, rsp_ovf;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.W(32), .OPW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
`ifdef ALU_ARB_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
`endif
    .rsp_data(rsp_data)
  );

  // Stand-in for the shared ALU
  always_comb begin
    case (alu_op)
      5'd1:    alu_out = alu_a + alu_b;
      5'd2:    alu_out = alu_a - alu_b;
      5'd3:    alu_out = alu_a & alu_b;
      5'd4:    alu_out = alu_a | alu_b;
      5'd5:    alu_out = alu_a ^ alu_b;
      5'd6:    alu_out = ~(alu_a | alu_b);
      default: alu_out = 32'd0;
    endcase
  end

  typedef struct {
    logic        id;
    logic [31:0] d;
    logic        z;
    logic        o;
  } exp_t;

  typedef struct {
    logic        id;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        z;
    logic        o;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: every response pulse pops the oldest expected result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req0_ready && req1_ready) chk("ready_onehot", 32'd1, 32'd0);
        if (rsp0_valid || rsp1_valid) begin
          chk("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 32'd0);
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", 32'(rsp1_valid), 32'(e.id));
            chk("rsp_data", rsp_data, e.d);
`ifdef ALU_ARB_FLAGS_EN
            chk("rsp_zero", 32'(rsp_zero), 32'(e.z));
            chk("rsp_ovf", 32'(rsp_ovf), 32'(e.o));
`endif
          end
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Called at posedge+1. Presents one op on requester id and waits for acceptance.
  // Returns at posedge+1 after acceptance, when the DUT is in EXEC.
  task automatic issue(input vec_t v);
    bit got;
    got = 0;
    if (v.id) begin
      req1_valid = 1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
    end else begin
      req0_valid = 1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
    end
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if ((v.id ? req1_ready : req0_ready) === 1'b1) begin
        got = 1;
        sb.push_back('{id: v.id, d: v.d, z: v.z, o: v.o});
      end
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    if (!got) chk("accept_timeout", 32'd1, 32'd0);
    else begin
      chk("exec_alu_op", 32'(alu_op), 32'(v.op));
      chk("exec_alu_a", alu_a, v.a);
      chk("exec_alu_b", alu_b, v.b);
      chk("exec_ready_low", 32'(req0_ready | req1_ready), 32'd0);
    end
  endtask

  // Called at posedge+1. Both requesters stay valid and the grant order is recorded.
  task automatic tie_run(input int n, output logic [2:0] order, output int got);
    got = 0; order = '0;
    req0_valid = 1; req0_op = 5'd2; req0_a = 32'd10;   req0_b = 32'd3;
    req1_valid = 1; req1_op = 5'd5; req1_a = 32'hF0;   req1_b = 32'hFF;
    for (int i = 0; i < 30 && got < n; i++) begin
      #1;
      if (req0_ready) begin
        order[got] = 1'b0; got++;
        sb.push_back('{id: 1'b0, d: 32'd7, z: 1'b0, o: 1'b0});
      end else if (req1_ready) begin
        order[got] = 1'b1; got++;
        sb.push_back('{id: 1'b1, d: 32'h0F, z: 1'b0, o: 1'b0});
      end
      @(posedge clk);
    end
    #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    logic [2:0] order;
    int         got;

    vecs[0] = '{1'b0, 5'd1, 32'd5,          32'd7,      32'd12,         1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'd2, 32'd3,          32'd10,     32'hFFFF_FFF9,  1'b0, 1'b0};
    vecs[2] = '{1'b0, 5'd3, 32'hF0F0,       32'hFF00,   32'hF000,       1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'd4, 32'h0F,         32'hF0,     32'hFF,         1'b0, 1'b0};
    vecs[4] = '{1'b1, 5'd6, 32'd0,          32'd0,      32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'd9, 32'd1,          32'd2,      32'd0,          1'b1, 1'b0};
    vecs[6] = '{1'b0, 5'd0, 32'd3,          32'd4,      32'd0,          1'b1, 1'b0};
    vecs[7] = '{1'b0, 5'd1, 32'h7FFF_FFFF,  32'd1,      32'h8000_0000,  1'b0, 1'b1};
    vecs[8] = '{1'b1, 5'd2, 32'd4,          32'd4,      32'd0,          1'b1, 1'b0};
    vecs[9] = '{1'b0, 5'd2, 32'h8000_0000,  32'd1,      32'h7FFF_FFFF,  1'b0, 1'b1};

    rst_n = 0;
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
    #3;
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_ready", 32'(req0_ready | req1_ready), 32'd0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Both valid continuously: grants alternate starting with req0
    tie_run(3, order, got);
    chk("tie_count", 32'(got), 32'd3);
    chk("tie_grant0", 32'(order[0]), 32'd0);
    chk("tie_grant1", 32'(order[1]), 32'd1);
    chk("tie_grant2", 32'(order[2]), 32'd0);
    drain();
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i]);
      drain();
      @(posedge clk); #1;
      chk("idle_alu_op", 32'(alu_op), 32'd0);
    end

    // Reset during EXEC: in-flight op dropped, outputs cleared at once
    issue(vecs[0]);
    rst_n = 0;
    #1;
    sb.delete();
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_alu_op", 32'(alu_op), 32'd0);
    chk("midrst_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
    @(negedge clk); rst_n = 1;
    repeat (4) @(posedge clk);
    #1;

    // After reset, req0 wins the first tie again; the op completes normally
    tie_run(1, order, got);
    chk("postrst_count", 32'(got), 32'd1);
    chk("postrst_grant", 32'(order[0]), 32'd0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
